// File: rtl/seq_decoder_pkg.sv
// seq_decoder_pkg
//   Shared types and constants for the registered one-hot decoder:
//   - state_t   : FSM encoding (IDLE, PULSE, GAP)
//   - CNT_W     : width of the pulse/gap cycle counter and decode counter
//   - onehot_w  : one-hot output width for an N-bit code (2**N)
package seq_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int CNT_W = 8;

  function automatic int onehot_w(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/seq_decoder2to4_decoder_core.sv
// decoder_core
//   Purely combinational N-to-2**N one-hot decoder with enable.
//   Ports:
//     en     in   1      when low the output is all-zero
//     code   in   N      binary code
//     onehot out  2**N   bit [code] set when en is high
module decoder_core
  import seq_decoder_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                   en,
  input  logic [N-1:0]           code,
  output logic [onehot_w(N)-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[code] = 1'b1;
    end
  end

endmodule

// File: rtl/seq_decoder2to4.sv
// seq_decoder2to4
//   Registered, handshaked binary-to-one-hot decoder. An accepted code drives
//   its one-hot line of y for PULSE_LEN cycles, then y is held low for GAP_LEN
//   cycles before the next code can be accepted.
//
//   Handshake: a code transfers on a rising edge where a_valid && a_ready.
//   a_ready is a pure function of the FSM state (high only in IDLE) and never
//   looks at a_valid; a and a_valid are ignored whenever a_ready is low.
//
//   Ports:
//     clk        in   1      clock, rising edge
//     rst        in   1      synchronous, active-high reset
//     a_valid    in   1      code present on a
//     a          in   N      binary code
//     a_ready    out  1      block accepts a code this cycle
//     y          out  2**N   registered one-hot output, zero when not pulsing
//     busy       out  1      high in PULSE or GAP
//     done       out  1      high during the last PULSE cycle
//     dec_count  out  8      completed decodes, wraps modulo 256
//     state      out  2      current FSM state (debug)
module seq_decoder2to4
  import seq_decoder_pkg::*;
#(
  parameter int N         = 2,
  parameter int PULSE_LEN = 3,
  parameter int GAP_LEN   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_valid,
  input  logic [N-1:0]           a,
  output logic                   a_ready,
  output logic [onehot_w(N)-1:0] y,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       dec_count,
  output state_t                 state
);

  localparam int Y_W = onehot_w(N);

  // Counter load values: the counter holds "cycles remaining after this one".
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  state_t           state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [N-1:0]     code_q, code_next;
  logic [CNT_W-1:0] count_next;
  logic [Y_W-1:0]   y_next;

  // y is registered from the *next* state and code, so it rises the cycle
  // after the accept edge and drops on the same edge that leaves PULSE.
  // Only one code feeds the decoder, so y can never be multi-hot.
  decoder_core #(.N(N)) u_core (
    .en     (state_next == PULSE),
    .code   (code_next),
    .onehot (y_next)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      code_q    <= '0;
      dec_count <= '0;
      y         <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      code_q    <= code_next;
      dec_count <= count_next;
      y         <= y_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    code_next  = code_q;
    count_next = dec_count;
    case (state)
      IDLE: begin
        if (a_valid) begin
          code_next  = a;
          cnt_next   = PULSE_LOAD;
          state_next = PULSE;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          count_next = dec_count + CNT_W'(1);
          if (GAP_LEN > 0) begin
            state_next = GAP;
            cnt_next   = GAP_LOAD;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs decoded from state only
  always_comb begin
    a_ready = (state == IDLE);
    busy    = (state != IDLE);
    done    = (state == PULSE) && (cnt == '0);
  end

endmodule

// File: tb/tb_seq_decoder2to4.sv
// tb_seq_decoder2to4
//   Directed bench for seq_decoder2to4. u_dut uses the default parameters
//   (PULSE_LEN=3, GAP_LEN=1); u_fast uses PULSE_LEN=1, GAP_LEN=0.
//   Inputs change and outputs are sampled on the falling edge.
module tb_seq_decoder2to4;
  import seq_decoder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, a_valid;
  logic [1:0] a;
  logic       a_ready, busy, done;
  logic [3:0] y;
  logic [7:0] dec_count;
  state_t     state;

  logic       rst_f, a_valid_f;
  logic [1:0] a_f;
  logic       a_ready_f, busy_f, done_f;
  logic [3:0] y_f;
  logic [7:0] dec_count_f;
  state_t     state_f;

  seq_decoder2to4 u_dut (
    .clk(clk), .rst(rst), .a_valid(a_valid), .a(a), .a_ready(a_ready),
    .y(y), .busy(busy), .done(done), .dec_count(dec_count), .state(state)
  );

  seq_decoder2to4 #(.N(2), .PULSE_LEN(1), .GAP_LEN(0)) u_fast (
    .clk(clk), .rst(rst_f), .a_valid(a_valid_f), .a(a_f), .a_ready(a_ready_f),
    .y(y_f), .busy(busy_f), .done(done_f), .dec_count(dec_count_f), .state(state_f)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_count = 8'd0;
  logic [3:0] onehot_tab [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; a_valid = 1'b1; a = 2'd2;
    rst_f = 1'b1; a_valid_f = 1'b0; a_f = 2'd0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (y !== 4'b0000 || a_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
          dec_count !== 8'd0 || state !== IDLE) begin
        $display("FAIL reset c=%0d: y=%b rdy=%b busy=%b done=%b cnt=%0d st=%0d want y=0000 rdy=1 busy=0 done=0 cnt=0 st=0",
                 c, y, a_ready, busy, done, dec_count, state);
        bad++;
      end
    end
    rst = 1'b0; a_valid = 1'b0;
    rst_f = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || y !== 4'b0000) begin
      $display("FAIL reset_no_accept: busy=%b y=%b want busy=0 y=0000", busy, y);
      bad++;
    end
  endtask

  task automatic test_each_code();
    logic [3:0] exp_y;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (a_ready !== 1'b1) begin
        $display("FAIL code%0d_ready: a_ready=%b want 1", k, a_ready);
        bad++;
      end
      a_valid = 1'b1; a = 2'(k);
      for (int c = 1; c <= 5; c++) begin
        @(negedge clk);
        exp_y = (c <= 3) ? onehot_tab[k] : 4'b0000;
        total++;
        if (y !== exp_y || done !== (c == 3) || busy !== (c <= 4) || a_ready !== (c == 5)) begin
          $display("FAIL code%0d_c%0d: y=%b done=%b busy=%b rdy=%b want y=%b done=%b busy=%b rdy=%b",
                   k, c, y, done, busy, a_ready, exp_y, (c == 3), (c <= 4), (c == 5));
          bad++;
        end
        if (c == 1) a_valid = 1'b0;
      end
      exp_count = exp_count + 8'd1;
      total++;
      if (dec_count !== exp_count) begin
        $display("FAIL code%0d_count: dec_count=%0d want %0d", k, dec_count, exp_count);
        bad++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int ph;
    a_valid = 1'b1; a = 2'd3;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      ph = c % 5;
      total++;
      if (y !== ((ph >= 1 && ph <= 3) ? 4'b1000 : 4'b0000) || a_ready !== (ph == 0) ||
          a_ready !== !busy) begin
        $display("FAIL b2b_c%0d: y=%b rdy=%b busy=%b want y=%b rdy=%b", c, y, a_ready, busy,
                 (ph >= 1 && ph <= 3) ? 4'b1000 : 4'b0000, (ph == 0));
        bad++;
      end
    end
    a_valid = 1'b0;
    exp_count = exp_count + 8'd4;
    total++;
    if (dec_count !== exp_count) begin
      $display("FAIL b2b_count: dec_count=%0d want %0d", dec_count, exp_count);
      bad++;
    end
  endtask

  task automatic test_input_change();
    a_valid = 1'b1; a = 2'd1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      total++;
      if (y !== ((c <= 3) ? 4'b0010 : 4'b0000)) begin
        $display("FAIL chg_c%0d: y=%b want %b", c, y, (c <= 3) ? 4'b0010 : 4'b0000);
        bad++;
      end
      if (c == 1) a = 2'd3;
      if (c == 4) a_valid = 1'b0;
    end
    exp_count = exp_count + 8'd1;
    total++;
    if (dec_count !== exp_count || a_ready !== 1'b1) begin
      $display("FAIL chg_end: dec_count=%0d rdy=%b want %0d 1", dec_count, a_ready, exp_count);
      bad++;
    end
  endtask

  task automatic test_reset_mid();
    a_valid = 1'b1; a = 2'd2;
    @(negedge clk);   // cycle 1
    a_valid = 1'b0;
    @(negedge clk);   // cycle 2
    total++;
    if (y !== 4'b0100) begin
      $display("FAIL rstmid_pre: y=%b want 0100", y);
      bad++;
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (y !== 4'b0000 || state !== IDLE || busy !== 1'b0 || a_ready !== 1'b1 ||
        done !== 1'b0 || dec_count !== 8'd0) begin
      $display("FAIL rstmid_post: y=%b st=%0d busy=%b rdy=%b done=%b cnt=%0d want 0000 0 0 1 0 0",
               y, state, busy, a_ready, done, dec_count);
      bad++;
    end
    rst = 1'b0;
    exp_count = 8'd0;
    a_valid = 1'b1; a = 2'd0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) a_valid = 1'b0;
      total++;
      if (y !== ((c <= 3) ? 4'b0001 : 4'b0000) || done !== (c == 3)) begin
        $display("FAIL rstmid_next_c%0d: y=%b done=%b want %b %b", c, y, done,
                 (c <= 3) ? 4'b0001 : 4'b0000, (c == 3));
        bad++;
      end
    end
    exp_count = exp_count + 8'd1;
    total++;
    if (dec_count !== exp_count) begin
      $display("FAIL rstmid_count: dec_count=%0d want %0d", dec_count, exp_count);
      bad++;
    end
  endtask

  task automatic test_fast();
    a_valid_f = 1'b1; a_f = 2'd2;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 8) a_valid_f = 1'b0;
      total++;
      if (y_f !== ((c % 2) ? 4'b0100 : 4'b0000) || done_f !== (c % 2 == 1) ||
          a_ready_f !== (c % 2 == 0)) begin
        $display("FAIL fast_c%0d: y=%b done=%b rdy=%b want y=%b done=%b rdy=%b", c, y_f, done_f,
                 a_ready_f, (c % 2) ? 4'b0100 : 4'b0000, (c % 2 == 1), (c % 2 == 0));
        bad++;
      end
    end
    total++;
    if (dec_count_f !== 8'd4) begin
      $display("FAIL fast_count: dec_count=%0d want 4", dec_count_f);
      bad++;
    end
  endtask

  task automatic test_wrap();
    int n;
    n = 256 - int'(exp_count);
    a_valid = 1'b1; a = 2'd0;
    for (int c = 1; c <= n * 5; c++) begin
      @(negedge clk);
      if (c == n * 5 - 2) begin
        total++;
        if (dec_count !== 8'd255 || done !== 1'b1) begin
          $display("FAIL wrap_pre: dec_count=%0d done=%b want 255 1", dec_count, done);
          bad++;
        end
      end
    end
    a_valid = 1'b0;
    total++;
    if (dec_count !== 8'd0) begin
      $display("FAIL wrap: dec_count=%0d want 0", dec_count);
      bad++;
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_each_code();
    test_back_to_back();
    test_input_change();
    test_reset_mid();
    test_fast();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
